// File: rtl/goldschmidt_ctrl.sv
// Goldschmidt divider control FSM.
// Sequences operand load, ITERS multiply-refine iterations of MUL_LAT cycles
// each, the quotient load, and a done/ack handshake. A zero divisor bypasses
// the iterations and reports err_div0 with done.
module goldschmidt_ctrl #(
  parameter int ITERS   = 4,
  parameter int MUL_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       dvsr_zero,
  input  logic       ack,
  output logic       ld_init,
  output logic       ld_iter,
  output logic       ld_q,
  output logic [3:0] iter_cnt,
  output logic       busy,
  output logic       done,
  output logic       err_div0
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ITER  = 3'd2;
  localparam logic [2:0] S_FINAL = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [3:0] SUB_LAST  = 4'(MUL_LAT - 1);
  localparam logic [3:0] ITER_LAST = 4'(ITERS - 1);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [3:0] sub_cnt;
  logic       iter_step;

  // An iteration commits in the last multiplier cycle of each ITER pass.
  assign iter_step = (state == S_ITER) && (sub_cnt == SUB_LAST);

  // Next-state decode; unused encodings fall back to IDLE.
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  if (start) state_nxt = dvsr_zero ? S_DONE : S_LOAD;
               else       state_nxt = S_IDLE;
      S_LOAD:  state_nxt = S_ITER;
      S_ITER:  state_nxt = (iter_step && (iter_cnt == ITER_LAST)) ? S_FINAL : S_ITER;
      S_FINAL: state_nxt = S_DONE;
      S_DONE:  state_nxt = ack ? S_IDLE : S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Iteration index and multiplier sub-cycle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iter_cnt <= 4'd0;
      sub_cnt  <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          sub_cnt <= 4'd0;
          if (start && !dvsr_zero) iter_cnt <= 4'd0;
        end
        S_LOAD: begin
          sub_cnt  <= 4'd0;
          iter_cnt <= 4'd0;
        end
        S_ITER: begin
          if (iter_step) begin
            sub_cnt <= 4'd0;
            if (iter_cnt != ITER_LAST) iter_cnt <= iter_cnt + 4'd1;
          end else begin
            sub_cnt <= sub_cnt + 4'd1;
          end
        end
        default: sub_cnt <= 4'd0;
      endcase
    end
  end

  // Divide-by-zero flag: set only on the IDLE shortcut, cleared by ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_div0 <= 1'b0;
    end else if ((state == S_IDLE) && start && dvsr_zero) begin
      err_div0 <= 1'b1;
    end else if ((state == S_DONE) && ack) begin
      err_div0 <= 1'b0;
    end
  end

  assign ld_init = (state == S_LOAD);
  assign ld_iter = iter_step;
  assign ld_q    = (state == S_FINAL);
  assign busy    = (state == S_LOAD) || (state == S_ITER) || (state == S_FINAL);
  assign done    = (state == S_DONE);

endmodule

// File: tb/tb_goldschmidt_ctrl.sv
// Testbench for goldschmidt_ctrl: a default instance (ITERS=4, MUL_LAT=2) and a
// minimal instance (ITERS=1, MUL_LAT=1) share stimulus; each is compared every
// cycle against a transaction-timing model built from the latency rules.
module tb_goldschmidt_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic dvsr_zero = 1'b0;
  logic ack = 1'b0;

  logic       li0, lt0, lq0, b0, d0, e0;
  logic       li1, lt1, lq1, b1, d1, e1;
  logic [3:0] ic0, ic1;

  goldschmidt_ctrl #(.ITERS(4), .MUL_LAT(2)) dut0 (
    .clk(clk), .reset(reset), .start(start), .dvsr_zero(dvsr_zero), .ack(ack),
    .ld_init(li0), .ld_iter(lt0), .ld_q(lq0), .iter_cnt(ic0),
    .busy(b0), .done(d0), .err_div0(e0)
  );

  goldschmidt_ctrl #(.ITERS(1), .MUL_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .dvsr_zero(dvsr_zero), .ack(ack),
    .ld_init(li1), .ld_iter(lt1), .ld_q(lq1), .iter_cnt(ic1),
    .busy(b1), .done(d1), .err_div0(e1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  // Model: per DUT, mode 0=idle, 1=in division (me = cycles since start edge), 2=done.
  int PI[2]  = '{4, 1};
  int PML[2] = '{2, 1};
  int mst[2] = '{0, 0};
  int me[2]  = '{0, 0};
  bit merr[2] = '{0, 0};

  function automatic logic [5:0] get_obs(int d);
    return (d == 0) ? {li0, lt0, lq0, b0, d0, e0} : {li1, lt1, lq1, b1, d1, e1};
  endfunction

  function automatic logic [3:0] get_iter(int d);
    return (d == 0) ? ic0 : ic1;
  endfunction

  // Expected {ld_init, ld_iter, ld_q, busy, done, err_div0}.
  function automatic logic [5:0] exp_out(int d);
    int t;
    int e;
    logic li, lt, lq, b, dn;
    t = PI[d] * PML[d];
    e = me[d];
    li = 0; lt = 0; lq = 0; b = 0; dn = 0;
    if (mst[d] == 1) begin
      li = (e == 1);
      lt = (e >= 2) && (e <= 1 + t) && (((e - 1) % PML[d]) == 0);
      lq = (e == 2 + t);
      b  = 1;
    end else if (mst[d] == 2) begin
      dn = 1;
    end
    return {li, lt, lq, b, dn, merr[d]};
  endfunction

  // Expected iteration index, or -1 where it is not defined.
  function automatic int exp_iter(int d);
    int t;
    t = PI[d] * PML[d];
    if (mst[d] != 1 || me[d] < 2) return -1;
    if (me[d] <= 1 + t) return (me[d] - 2) / PML[d];
    return PI[d] - 1;
  endfunction

  task automatic model_update();
    for (int d = 0; d < 2; d++) begin
      if (!reset) begin
        mst[d] = 0; merr[d] = 0; me[d] = 0;
      end else begin
        case (mst[d])
          0: if (start) begin
               if (dvsr_zero) begin mst[d] = 2; merr[d] = 1; end
               else begin mst[d] = 1; me[d] = 1; end
             end
          1: begin
               me[d] = me[d] + 1;
               if (me[d] == 3 + PI[d] * PML[d]) begin mst[d] = 2; merr[d] = 0; end
             end
          default: if (ack) begin mst[d] = 0; merr[d] = 0; end
        endcase
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; ack = 1'b0; dvsr_zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      advance();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (get_obs(d) !== 6'b0) $display("FAIL reset_outs dut%0d got=%b exp=%b", d, get_obs(d), 6'b0);
        else passed++;
        checks++;
        if (get_iter(d) !== 4'd0) $display("FAIL reset_iter dut%0d got=%0d exp=0", d, get_iter(d));
        else passed++;
      end
    end
    start = 1'b0;
    reset = 1'b1;
    advance();
  endtask

  task automatic test_normal();
    start = 1'b1; dvsr_zero = 1'b0; ack = 1'b0;
    for (int i = 0; i < 14; i++) begin
      advance();
      start = 1'b0;
      if (i == 12) ack = 1'b1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (get_obs(d) !== exp_out(d)) $display("FAIL normal dut%0d cyc=%0d got=%b exp=%b", d, cyc, get_obs(d), exp_out(d));
        else passed++;
        if (exp_iter(d) >= 0) begin
          checks++;
          if (get_iter(d) !== 4'(exp_iter(d))) $display("FAIL normal_iter dut%0d cyc=%0d got=%0d exp=%0d", d, cyc, get_iter(d), exp_iter(d));
          else passed++;
        end
      end
    end
    ack = 1'b0;
    advance();
  endtask

  task automatic test_div0();
    start = 1'b1; dvsr_zero = 1'b1; ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      advance();
      start = 1'b0;
      dvsr_zero = 1'b0;
      ack = (i == 2);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (get_obs(d) !== exp_out(d)) $display("FAIL div0 dut%0d cyc=%0d got=%b exp=%b", d, cyc, get_obs(d), exp_out(d));
        else passed++;
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_hold_ignore();
    int loads;
    loads = 0;
    start = 1'b1; dvsr_zero = 1'b0; ack = 1'b0;
    for (int i = 0; i < 40; i++) begin
      advance();
      start = (i % 3 == 1);
      dvsr_zero = (i % 5 == 2);
      if (li0) loads++;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (get_obs(d) !== exp_out(d)) $display("FAIL hold dut%0d cyc=%0d got=%b exp=%b", d, cyc, get_obs(d), exp_out(d));
        else passed++;
      end
    end
    checks++;
    if (loads !== 1) $display("FAIL hold_single_load got=%0d exp=1", loads);
    else passed++;
    start = 1'b0; dvsr_zero = 1'b0; ack = 1'b1;
    advance();
    advance();
    ack = 1'b0;
  endtask

  task automatic test_async_reset();
    start = 1'b1; dvsr_zero = 1'b0; ack = 1'b0;
    advance();
    start = 1'b0;
    while (me[0] < 6) advance();
    checks++;
    if (ic0 !== 4'd2) $display("FAIL areset_pre_iter got=%0d exp=2", ic0);
    else passed++;
    #2 reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      mst[d] = 0; merr[d] = 0; me[d] = 0;
      checks++;
      if (get_obs(d) !== 6'b0) $display("FAIL areset_outs dut%0d got=%b exp=%b", d, get_obs(d), 6'b0);
      else passed++;
      checks++;
      if (get_iter(d) !== 4'd0) $display("FAIL areset_iter dut%0d got=%0d exp=0", d, get_iter(d));
      else passed++;
    end
    advance();
    reset = 1'b1;
    advance();
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      advance();
      start = 1'b0;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (get_obs(d) !== exp_out(d)) $display("FAIL areset_restart dut%0d cyc=%0d got=%b exp=%b", d, cyc, get_obs(d), exp_out(d));
        else passed++;
      end
    end
    checks++;
    if (lq0 !== 1'b0 || me[0] != 4) $display("FAIL areset_restart_pos got=%0d exp=4", me[0]);
    else passed++;
    reset = 1'b0;
    advance();
    reset = 1'b1;
    advance();
  endtask

  task automatic test_back_to_back();
    int run;
    run = 0;
    start = 1'b1; ack = 1'b1; dvsr_zero = 1'b0;
    for (int i = 0; i < 60; i++) begin
      advance();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (get_obs(d) !== exp_out(d)) $display("FAIL b2b dut%0d cyc=%0d got=%b exp=%b", d, cyc, get_obs(d), exp_out(d));
        else passed++;
      end
      if (d0) run++;
      else if (run != 0) begin
        checks++;
        if (run !== 1) $display("FAIL b2b_done_len got=%0d exp=1", run);
        else passed++;
        run = 0;
      end
    end
    start = 1'b0; ack = 1'b1;
    advance();
    advance();
    ack = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      start     = ($urandom_range(0, 2) == 0);
      dvsr_zero = ($urandom_range(0, 3) == 0);
      ack       = ($urandom_range(0, 2) == 0);
      advance();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (get_obs(d) !== exp_out(d)) $display("FAIL random dut%0d cyc=%0d got=%b exp=%b", d, cyc, get_obs(d), exp_out(d));
        else passed++;
        if (exp_iter(d) >= 0) begin
          checks++;
          if (get_iter(d) !== 4'(exp_iter(d))) $display("FAIL random_iter dut%0d cyc=%0d got=%0d exp=%0d", d, cyc, get_iter(d), exp_iter(d));
          else passed++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_div0();
    test_hold_ignore();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/goldschmidt_ctrl.md
GOLDSCHMIDT_CTRL -- requirements
Module: goldschmidt_ctrl

Interface
REQ-001 Parameter ITERS, default 4, number of Goldschmidt iterations, legal range 1..15.
REQ-002 Parameter MUL_LAT, default 2, cycles per iteration (multiplier latency), legal range 1..8.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin one division; sampled only in IDLE.
REQ-006 dvsr_zero  input  1  datapath flag: divisor operand equals zero.
REQ-007 ack  input  1  consumer acknowledge of a completed result.
REQ-008 ld_init  output  1  load normalized operands into N/D registers, select init mux path.
REQ-009 ld_iter  output  1  load N*F, D*F into N/D registers (one iteration commit).
REQ-010 ld_q  output  1  load N register into quotient register.
REQ-011 iter_cnt  output  4  index of the current iteration, 0..ITERS-1.
REQ-012 busy  output  1  high from LOAD through FINAL.
REQ-013 done  output  1  result (or error) available, held until ack.
REQ-014 err_div0  output  1  qualifies done: division by zero, quotient invalid.

Function
REQ-015 FSM states IDLE, LOAD, ITER, FINAL, DONE; binary encoded; the 3 unused codes SHALL return to IDLE on the next edge.
REQ-016 IDLE: start=1 and dvsr_zero=0 -> LOAD; start=1 and dvsr_zero=1 -> DONE with err_div0 set; otherwise stay.
REQ-017 LOAD: exactly one cycle; ld_init=1; iter_cnt and internal sub-cycle counter cleared to 0; -> ITER.
REQ-018 ITER: sub counter counts 0..MUL_LAT-1; ld_iter=1 only in the cycle where sub counter = MUL_LAT-1.
REQ-019 ITER: on ld_iter cycle, sub counter wraps to 0 and iter_cnt increments; if iter_cnt = ITERS-1 -> FINAL instead (iter_cnt holds ITERS-1).
REQ-020 FINAL: exactly one cycle; ld_q=1; -> DONE.
REQ-021 DONE: done=1; err_div0 holds value set on entry (1 only via IDLE divide-by-zero path, else 0); ack=1 -> IDLE, done and err_div0 clear on that edge.
REQ-022 ack in DONE takes effect in the same cycle it is asserted; ack outside DONE ignored.
REQ-023 start outside IDLE ignored (no queuing); start and ack both high in DONE -> IDLE only; new start must be re-asserted in IDLE.
REQ-024 Latency, normal path: start sampled at edge 0 -> ld_init cycle 1 -> ld_iter cycles 1+k*MUL_LAT (k=1..ITERS) -> ld_q cycle 2+ITERS*MUL_LAT -> done from cycle 3+ITERS*MUL_LAT.
REQ-025 Latency, zero-divisor path: done=1, err_div0=1 from cycle 1; no ld_init/ld_iter/ld_q pulse.
REQ-026 ld_init, ld_iter, ld_q mutually exclusive; each a single-cycle pulse, all Moore outputs decoded from registered state/counters.
REQ-027 dvsr_zero sampled only in IDLE with start; changes during ITER have no effect.

Reset
REQ-028 reset=0 forces IDLE, iter_cnt=0, sub counter=0, err_div0=0 immediately, independent of clk.
REQ-029 While in reset and after release: ld_init=ld_iter=ld_q=busy=done=0.
REQ-030 Reset mid-operation (any state) aborts the division; no ld_q issued; first start after release begins a fresh LOAD.

Verification
REQ-031 Defaults, start pulse cycle 0, dvsr_zero=0 -> ld_init at 1, ld_iter at 3,5,7,9 with iter_cnt 0,1,2,3, ld_q at 10, done=1 at 11, busy=1 cycles 1..10.
REQ-032 start with dvsr_zero=1 -> done=1, err_div0=1 at cycle 1, busy=0, no load pulses; ack -> IDLE, done=0 next cycle.
REQ-033 Hold ack=0 for 20 cycles in DONE -> done stays 1; start pulses during ITER and DONE -> no second LOAD.
REQ-034 reset=0 asserted mid-ITER (iter_cnt=2) between edges -> outputs zero without waiting for clk; start after release -> ld_init one cycle later.
REQ-035 ITERS=1, MUL_LAT=1: start cycle 0 -> ld_init 1, ld_iter 2, ld_q 3, done 4.
REQ-036 start and ack held high continuously -> back-to-back divisions, each done lasts exactly one cycle, 1 idle cycle between.
